// File: rtl/ysyx_22050019_pipe_pkg.sv
// Shared types and payload widths for the pipeline-boundary registers.
// Every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) sizes its payload from here.
package ysyx_22050019_pipe_pkg;

    // Encoding is {skid_v, main_v}; 2'b10 can never be reached.
    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'b00,
        PIPE_FULL  = 2'b01,
        PIPE_SKID  = 2'b11
    } pipe_state_e;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned PC_W     = 64;
    localparam int unsigned INST_W   = 32;
    localparam int unsigned CTRL_W   = 16;
    localparam int unsigned IF_ID_W  = PC_W + INST_W;
    localparam int unsigned ID_EX_W  = PC_W + INST_W + 2 * XLEN + CTRL_W;
    localparam int unsigned EX_MEM_W = PC_W + INST_W + 2 * XLEN + CTRL_W;
    localparam int unsigned MEM_WB_W = PC_W + INST_W + XLEN + CTRL_W;

    function automatic logic [1:0] occ_of(input logic skid_v, input logic main_v);
        return {1'b0, skid_v} + {1'b0, main_v};
    endfunction

endpackage

// File: rtl/ysyx_22050019_pipe_stage.sv
// Valid/ready pipeline-boundary register with synchronous flush and an optional
// 2-entry skid buffer that keeps in_ready_o a pure register output.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both 1.
// valid never depends on ready; once out_valid_o is high the head payload holds
// steady until it is taken (or a flush kills it).
module ysyx_22050019_pipe_stage
    import ysyx_22050019_pipe_pkg::*;
#(
    parameter int unsigned DATA_W          = IF_ID_W,
    parameter bit          SKID            = 1'b1,
    parameter bit          CLEAR_ON_BUBBLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o,
    output pipe_state_e       dbg_state_o
);

    logic              w_push;
    logic              w_pop;
    logic              w_main_v;
    logic              w_skid_v;
    logic [DATA_W-1:0] w_main_d;

    assign w_push = in_valid_i & in_ready_o;
    assign w_pop  = w_main_v & out_ready_i;

    if (SKID) begin : g_skid
        pipe_state_e       r_state;
        pipe_state_e       w_state_nxt;
        logic [1:0]        w_bits;
        logic              w_load_main;
        logic              w_main_from_skid;
        logic              w_load_skid;
        logic [DATA_W-1:0] r_main_d;
        logic [DATA_W-1:0] r_skid_d;

        assign w_bits     = r_state;
        assign w_main_v   = w_bits[0];
        assign w_skid_v   = w_bits[1];
        assign w_main_d   = r_main_d;
        assign in_ready_o = ~w_bits[1];

        always_comb begin
            w_state_nxt      = r_state;
            w_load_main      = 1'b0;
            w_main_from_skid = 1'b0;
            w_load_skid      = 1'b0;
            if (flush_i) begin
                // Flush wins: the input of this cycle is dropped, no data moves.
                w_state_nxt = PIPE_EMPTY;
            end else begin
                case (r_state)
                    PIPE_EMPTY: begin
                        if (w_push) begin
                            w_state_nxt = PIPE_FULL;
                            w_load_main = 1'b1;
                        end
                    end
                    PIPE_FULL: begin
                        if (w_push && w_pop) begin
                            w_load_main = 1'b1;
                        end else if (w_push) begin
                            w_state_nxt = PIPE_SKID;
                            w_load_skid = 1'b1;
                        end else if (w_pop) begin
                            w_state_nxt = PIPE_EMPTY;
                        end
                    end
                    PIPE_SKID: begin
                        if (w_pop) begin
                            w_state_nxt      = PIPE_FULL;
                            w_main_from_skid = 1'b1;
                        end
                    end
                    default: w_state_nxt = PIPE_EMPTY;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= PIPE_EMPTY;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_main_d <= '0;
                r_skid_d <= '0;
            end else begin
                if (w_load_main) begin
                    r_main_d <= in_data_i;
                end else if (w_main_from_skid) begin
                    r_main_d <= r_skid_d;
                end
                if (w_load_skid) begin
                    r_skid_d <= in_data_i;
                end
            end
        end

        assign dbg_state_o = r_state;
    end else begin : g_single
        logic              r_main_v;
        logic [DATA_W-1:0] r_main_d;

        assign w_main_v   = r_main_v;
        assign w_skid_v   = 1'b0;
        assign w_main_d   = r_main_d;
        assign in_ready_o = ~r_main_v | out_ready_i;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_main_v <= 1'b0;
                r_main_d <= '0;
            end else if (flush_i) begin
                r_main_v <= 1'b0;
            end else if (w_push) begin
                r_main_v <= 1'b1;
                r_main_d <= in_data_i;
            end else if (w_pop) begin
                r_main_v <= 1'b0;
            end
        end

        assign dbg_state_o = r_main_v ? PIPE_FULL : PIPE_EMPTY;
    end

    assign out_valid_o = w_main_v;
    assign out_data_o  = (CLEAR_ON_BUBBLE && !w_main_v) ? '0 : w_main_d;
    assign occupancy_o = occ_of(w_skid_v, w_main_v);

endmodule

// File: tb/tb_ysyx_22050019_pipe_stage.sv
// Bench for the pipeline-boundary register: three instances (skid, single, skid
// without bubble clearing) share one stimulus stream, each tracked by a queue model.
module tb_ysyx_22050019_pipe_stage;
    import ysyx_22050019_pipe_pkg::*;

    localparam int W = IF_ID_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         flush_i = 1'b0;
    logic         in_valid_i = 1'b0;
    logic         out_ready_i = 1'b0;
    logic [W-1:0] in_data_i = '0;

    logic a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
    logic [W-1:0] a_out_data, b_out_data, c_out_data;
    logic [1:0] a_occ, b_occ, c_occ;
    pipe_state_e a_state, b_state, c_state;

    ysyx_22050019_pipe_stage #(.DATA_W(W), .SKID(1'b1), .CLEAR_ON_BUBBLE(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(a_in_ready), .in_data_i(in_data_i),
        .out_valid_o(a_out_valid), .out_ready_i(out_ready_i), .out_data_o(a_out_data),
        .occupancy_o(a_occ), .dbg_state_o(a_state)
    );

    ysyx_22050019_pipe_stage #(.DATA_W(W), .SKID(1'b0), .CLEAR_ON_BUBBLE(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(b_in_ready), .in_data_i(in_data_i),
        .out_valid_o(b_out_valid), .out_ready_i(out_ready_i), .out_data_o(b_out_data),
        .occupancy_o(b_occ), .dbg_state_o(b_state)
    );

    ysyx_22050019_pipe_stage #(.DATA_W(W), .SKID(1'b1), .CLEAR_ON_BUBBLE(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(c_in_ready), .in_data_i(in_data_i),
        .out_valid_o(c_out_valid), .out_ready_i(out_ready_i), .out_data_o(c_out_data),
        .occupancy_o(c_occ), .dbg_state_o(c_state)
    );

    // ---------------- scoreboard ----------------
    // Each queue holds the payloads currently inside that instance, head first.
    logic [W-1:0] exp_a_q[$];
    logic [W-1:0] exp_b_q[$];
    logic [W-1:0] exp_c_q[$];
    logic [W-1:0] c_last;
    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] exp_state(input int n);
        return (n == 0) ? W'(PIPE_EMPTY) : (n == 1) ? W'(PIPE_FULL) : W'(PIPE_SKID);
    endfunction

    task automatic check_outputs();
        chk("a_valid", W'(a_out_valid), W'(exp_a_q.size() > 0));
        chk("a_data", a_out_data, (exp_a_q.size() > 0) ? exp_a_q[0] : '0);
        chk("a_occ", W'(a_occ), W'(exp_a_q.size()));
        chk("a_state", W'(a_state), exp_state(exp_a_q.size()));
        chk("b_valid", W'(b_out_valid), W'(exp_b_q.size() > 0));
        chk("b_data", b_out_data, (exp_b_q.size() > 0) ? exp_b_q[0] : '0);
        chk("b_occ", W'(b_occ), W'(exp_b_q.size()));
        chk("c_valid", W'(c_out_valid), W'(exp_c_q.size() > 0));
        chk("c_data", c_out_data, (exp_c_q.size() > 0) ? exp_c_q[0] : c_last);
        chk("c_occ", W'(c_occ), W'(exp_c_q.size()));
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic rdy, input logic fl);
        bit pa, pb, pc, oa, ob, oc;
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = rdy;
        flush_i     = fl;
        #1;
        chk("a_in_ready", W'(a_in_ready), W'(exp_a_q.size() < 2));
        chk("b_in_ready", W'(b_in_ready), W'(exp_b_q.size() == 0 || rdy));
        chk("c_in_ready", W'(c_in_ready), W'(exp_c_q.size() < 2));
        pa = v && exp_a_q.size() < 2;
        pb = v && (exp_b_q.size() == 0 || rdy);
        pc = v && exp_c_q.size() < 2;
        oa = rdy && exp_a_q.size() > 0;
        ob = rdy && exp_b_q.size() > 0;
        oc = rdy && exp_c_q.size() > 0;
        @(posedge clk);
        if (fl) begin
            exp_a_q.delete();
            exp_b_q.delete();
            exp_c_q.delete();
        end else begin
            if (oa) void'(exp_a_q.pop_front());
            if (pa) exp_a_q.push_back(d);
            if (ob) void'(exp_b_q.pop_front());
            if (pb) exp_b_q.push_back(d);
            if (oc) void'(exp_c_q.pop_front());
            if (pc) exp_c_q.push_back(d);
        end
        if (exp_c_q.size() > 0) c_last = exp_c_q[0];
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom};
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        int item;
        c_last = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs();
        chk("rst_a_in_ready", W'(a_in_ready), W'(1));
        chk("rst_b_in_ready", W'(b_in_ready), W'(1));
        rst_n = 1'b1;
        @(negedge clk);

        // Full-rate stream 1..8
        for (int i = 1; i <= 8; i++) cycle(1'b1, W'(i), 1'b1, 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);

        // Backpressure: downstream stalls for 3 cycles when 0x4 is offered
        item = 1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            logic rdy, v, acc;
            rdy = !(cyc >= 3 && cyc <= 5);
            v   = (item <= 8);
            acc = v && exp_a_q.size() < 2;
            cycle(v, W'(item), rdy, 1'b0);
            if (acc) item++;
        end
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

        // Flush while in SKID with a live input, then flush+push from EMPTY
        cycle(1'b1, W'('h11), 1'b1, 1'b0);
        cycle(1'b1, W'('h22), 1'b0, 1'b0);
        cycle(1'b1, W'('hAA), 1'b0, 1'b1);
        cycle(1'b1, W'('hBB), 1'b1, 1'b1);
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);

        // Alternating downstream ready
        for (int i = 0; i < 10; i++) cycle(1'b1, rnd_data(), (i % 2) == 0, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset between edges while holding 0xDEAD
        cycle(1'b1, W'('hDEAD), 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_a_valid", W'(a_out_valid), W'(0));
        chk("arst_a_data", a_out_data, '0);
        chk("arst_a_occ", W'(a_occ), W'(0));
        chk("arst_b_valid", W'(b_out_valid), W'(0));
        chk("arst_c_data", c_out_data, '0);
        exp_a_q.delete();
        exp_b_q.delete();
        exp_c_q.delete();
        c_last = '0;
        in_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_a_in_ready", W'(a_in_ready), W'(1));
        chk("rel_a_occ", W'(a_occ), W'(0));
        chk("rel_c_in_ready", W'(c_in_ready), W'(1));

        // Single item without bubble clearing: 0x55 stays visible after the pop
        cycle(1'b1, W'('h55), 1'b1, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("c_hold_55", c_out_data, W'('h55));

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, rnd_data(), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 24) == 0);
        end
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
